// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared state encodings, opcodes and select codes for multicycle_ctrl_v2.
package mctrl_pkg;
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;
    localparam logic [3:0] S_JAL       = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
endpackage

// File: rtl/mctrl_retire_counter.sv
// mctrl_retire_counter: wrapping count of retired instructions.
module mctrl_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else if (inc) count_q <= count_q + 1'b1;
    end
    assign count = count_q;
endmodule

// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2: multicycle MIPS control FSM with memory stalls, illegal-op trap and retire count.
// Define MCTRL_JAL_EN to decode opcode 000011 as JAL instead of trapping.
module multicycle_ctrl_v2
    import mctrl_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int CNT_W     = 32,
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opCode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNe,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          RegDst,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);
    logic [3:0] state_q, state_d, dec_d;
    logic       illegal_q, done;
    // The zero flag gates branches in the datapath, so the FSM never looks at it.
    logic       unused_zero;
    assign unused_zero = zero;

    always_comb begin
        dec_d = S_TRAP;
        case (opCode)
            OP_RTYPE:      dec_d = S_R_EXEC;
            OP_ADDI:       dec_d = S_ADDI_EXEC;
            OP_LW, OP_SW:  dec_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: dec_d = S_BRANCH;
            OP_J:          dec_d = S_JUMP;
`ifdef MCTRL_JAL_EN
            OP_JAL:        dec_d = S_JAL;
`endif
            default:       dec_d = S_TRAP;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        done    = 1'b0;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = dec_d;
            S_MEM_ADDR:  state_d = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
                done    = mem_ready;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: done = 1'b1;
`ifdef MCTRL_JAL_EN
            S_JAL:       done = 1'b1;
`endif
            S_TRAP:      state_d = TRAP_HALT ? S_TRAP : S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    mctrl_retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk   (clk),
        .reset (reset),
        .inc   (done),
        .count (retired)
    );

    assign illegal_op = illegal_q;
    assign state_o    = state_q;

    // Reset forces every control low in the same cycle so no write slips through.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_ADD;
        MemtoReg    = M2R_ALU;
        RegDst      = RD_RT;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:    ALUSrcB = 2'b11;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_MEM;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RD;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = (opCode == OP_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDI_WB:   RegWrite = 1'b1;
`ifdef MCTRL_JAL_EN
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    RegWrite = 1'b1;
                    RegDst   = RD_RA;
                    MemtoReg = M2R_PC;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
